// File: rtl/shift_exec_unit_pkg.sv
// Shared types and helpers for the RV32 execute-stage shift unit.
// Holds the operation encoding, default widths and the bit-reversal helper.
package shift_pkg;

    localparam int DATA_WIDTH_C  = 32;
    localparam int SHIFT_WIDTH_C = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_RSVD = 2'b10,
        SHIFT_SRA  = 2'b11
    } shift_op_e;

    // Right shifts reuse the left shifter by mirroring the word on both sides.
    function automatic logic [DATA_WIDTH_C-1:0] bit_reverse(input logic [DATA_WIDTH_C-1:0] x);
        logic [DATA_WIDTH_C-1:0] r;
        for (int i = 0; i < DATA_WIDTH_C; i++) begin
            r[i] = x[DATA_WIDTH_C-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_exec_unit_if.sv
// Handshake bundle between decode/register-read, the shift unit and write-back.
// The slave modport is the unit's view; master is the surrounding pipeline's view.
interface shift_exec_unit_if
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_C,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_C
);
    logic                   valid_i;
    logic                   ready_o;
    logic [1:0]             op_i;
    logic [DATA_WIDTH-1:0]  data_i;
    logic [SHIFT_WIDTH-1:0] shift_value_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [DATA_WIDTH-1:0]  data_o;
    logic                   illegal_o;

    modport slave (
        input  valid_i, op_i, data_i, shift_value_i, ready_i,
        output ready_o, valid_o, data_o, illegal_o
    );

    modport master (
        output valid_i, op_i, data_i, shift_value_i, ready_i,
        input  ready_o, valid_o, data_o, illegal_o
    );
endinterface

// File: rtl/shifter_left_logical.sv
// Combinational left-logical barrel shifter shared by the execute stage.
module shifter_left_logical #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    output logic [DATA_WIDTH-1:0]  o_data
);
    assign o_data = i_data << i_shift;
endmodule

// File: rtl/shift_exec_unit.sv
// Registered SLL/SRL/SRA execute stage with a 2-entry skid buffer towards write-back.
// Right shifts mirror the operand around a left shifter; a second shifter builds the SRA fill mask.
module shift_exec_unit
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_C,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_C
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    shift_exec_unit_if.slave      bus
);
    logic [DATA_WIDTH-1:0] w_shl_in;
    logic [DATA_WIDTH-1:0] w_shl_out;
    logic [DATA_WIDTH-1:0] w_mask_out;
    logic [DATA_WIDTH-1:0] w_srl;
    logic [DATA_WIDTH-1:0] w_sra_fill;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_illegal;
    logic                  w_accept;
    shift_op_e             w_op;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_illegal;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_illegal;

    assign w_op     = shift_op_e'(bus.op_i);
    assign w_shl_in = (w_op == SHIFT_SLL) ? bus.data_i : bit_reverse(bus.data_i);

    shifter_left_logical #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shl_operand (
        .i_data  (w_shl_in),
        .i_shift (bus.shift_value_i),
        .o_data  (w_shl_out)
    );

    // Mask path: mirrored ones shifted left gives the bits an SRA must fill with the sign.
    shifter_left_logical #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shl_mask (
        .i_data  ({DATA_WIDTH{1'b1}}),
        .i_shift (bus.shift_value_i),
        .o_data  (w_mask_out)
    );

    assign w_srl      = bit_reverse(w_shl_out);
    assign w_sra_fill = bus.data_i[DATA_WIDTH-1] ? ~bit_reverse(w_mask_out) : '0;

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (w_op)
            SHIFT_SLL:  w_result = w_shl_out;
            SHIFT_SRL:  w_result = w_srl;
            SHIFT_SRA:  w_result = w_srl | w_sra_fill;
            default:    w_illegal = 1'b1;
        endcase
    end

    assign w_accept = bus.valid_i & ~r_skid_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_data    <= '0;
            r_skid_illegal <= 1'b0;
        end else if (!r_out_valid || bus.ready_i) begin
            // Skid drains first; ready_o was low so nothing new can arrive this cycle.
            if (r_skid_valid) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= r_skid_data;
                r_out_illegal <= r_skid_illegal;
                r_skid_valid  <= 1'b0;
            end else if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= w_result;
                r_out_illegal <= w_illegal;
            end else begin
                r_out_valid   <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid   <= 1'b1;
            r_skid_data    <= w_result;
            r_skid_illegal <= w_illegal;
        end
    end

    assign bus.ready_o   = ~r_skid_valid;
    assign bus.valid_o   = r_out_valid;
    assign bus.data_o    = r_out_data;
    assign bus.illegal_o = r_out_illegal;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench for shift_exec_unit: directed plan steps plus random traffic
// checked against a FIFO-of-results reference model.
module tb_shift_exec_unit;
    import shift_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [32:0] exp_q[$];

    shift_exec_unit_if #(.DATA_WIDTH(32), .SHIFT_WIDTH(5)) bus ();

    shift_exec_unit #(.DATA_WIDTH(32), .SHIFT_WIDTH(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        logic signed [31:0] sd;
        sd = d;
        case (op)
            2'b00:   return {1'b0, d << s};
            2'b01:   return {1'b0, d >> s};
            2'b11:   return {1'b0, 32'(sd >>> s)};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check against model occupancy, update model at the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic rdy, input logic use_exp,
                        input logic [31:0] exp_d, input logic exp_ill, output logic acc);
        logic [32:0] front;
        logic        occ_ready;
        @(negedge clk);
        bus.valid_i       = v;
        bus.op_i          = op;
        bus.data_i        = d;
        bus.shift_value_i = s;
        bus.ready_i       = rdy;
        #1;
        occ_ready = (exp_q.size() < 2);
        chk("ready_o", 32'(bus.ready_o), 32'(occ_ready));
        chk("valid_o", 32'(bus.valid_o), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0 && rdy) begin
            front = exp_q.pop_front();
            chk("data_o", bus.data_o, front[31:0]);
            chk("illegal_o", 32'(bus.illegal_o), 32'(front[32]));
        end
        acc = v && occ_ready;
        if (acc) exp_q.push_back(use_exp ? {exp_ill, exp_d} : ref_model(op, d, s));
        $display("step v=%0b op=%0d d=%h s=%0d rdy=%0b acc=%0b q=%0d", v, op, d, s, rdy, acc, exp_q.size());
        @(posedge clk);
    endtask

    initial begin
        logic acc;
        logic [1:0]  r_op;
        logic [31:0] r_d;
        logic [4:0]  r_s;
        logic        r_v;

        rst_n = 1'b0;
        bus.valid_i = 1'b0; bus.op_i = 2'b00; bus.data_i = '0;
        bus.shift_value_i = '0; bus.ready_i = 1'b0;
        #12;
        chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst_ready_o", 32'(bus.ready_o), 32'd1);
        chk("rst_data_o", bus.data_o, 32'd0);
        chk("rst_illegal_o", 32'(bus.illegal_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed plan vectors with hand-derived expectations.
        step(1, 2'b00, 32'h00000001, 4,  1, 1, 32'h00000010, 0, acc);
        step(1, 2'b01, 32'hfedcba98, 4,  1, 1, 32'h0fedcba9, 0, acc);
        step(1, 2'b11, 32'hfedcba98, 4,  1, 1, 32'hffedcba9, 0, acc);
        step(1, 2'b11, 32'h7edcba98, 4,  1, 1, 32'h07edcba9, 0, acc);
        step(1, 2'b11, 32'hfedcba98, 31, 1, 1, 32'hffffffff, 0, acc);
        step(1, 2'b01, 32'hfedcba98, 31, 1, 1, 32'h00000001, 0, acc);
        step(1, 2'b00, 32'hfedcba98, 31, 1, 1, 32'h00000000, 0, acc);
        step(1, 2'b00, 32'hfedcba98, 0,  1, 1, 32'hfedcba98, 0, acc);
        step(1, 2'b01, 32'hfedcba98, 0,  1, 1, 32'hfedcba98, 0, acc);
        step(1, 2'b11, 32'hfedcba98, 0,  1, 1, 32'hfedcba98, 0, acc);
        step(0, 2'b00, 32'h0,        0,  1, 0, 32'h0,        0, acc);

        // Backpressure: two accepts fill both entries, third is held off.
        step(1, 2'b00, 32'h00000001, 1,  0, 1, 32'h00000002, 0, acc);
        step(1, 2'b00, 32'h00000001, 2,  0, 1, 32'h00000004, 0, acc);
        step(1, 2'b00, 32'h00000001, 3,  0, 1, 32'h00000008, 0, acc);
        chk("held_off", 32'(acc), 32'd0);
        step(0, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0, acc);
        step(0, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0, acc);
        step(0, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0, acc);

        // Streaming: 1<<0 .. 1<<7 back to back.
        for (int i = 0; i < 8; i++)
            step(1, 2'b00, 32'h00000001, 5'(i), 1, 1, 32'h1 << i, 0, acc);
        step(0, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0, acc);
        step(0, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0, acc);

        // Reserved op, then fill both entries and reset asynchronously mid-cycle.
        step(1, 2'b10, 32'hffffffff, 3, 1, 1, 32'h00000000, 1, acc);
        step(1, 2'b10, 32'hffffffff, 3, 0, 1, 32'h00000000, 1, acc);
        step(1, 2'b01, 32'hffffffff, 3, 0, 1, 32'h1fffffff, 0, acc);
        step(0, 2'b00, 32'h0, 0, 0, 0, 32'h0, 0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("async_rst_ready_o", 32'(bus.ready_o), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step(0, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0, acc);

        // Random traffic with producer hold while stalled.
        r_v = 0; r_op = 0; r_d = 0; r_s = 0; acc = 1;
        for (int i = 0; i < 400; i++) begin
            if (!(r_v && !acc)) begin
                r_v  = ($urandom_range(0, 3) != 0);
                r_op = 2'($urandom_range(0, 3));
                r_d  = $urandom;
                r_s  = 5'($urandom_range(0, 31));
            end
            step(r_v, r_op, r_d, r_s, ($urandom_range(0, 2) != 0), 0, 32'h0, 0, acc);
        end
        for (int i = 0; i < 4; i++)
            step(0, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
